gpp_boot_ctrl: RTL and testbench

- Hardware boot sequencer for the GPP, sitting between a host word stream and GPP_TOP's memory-load and control ports.
- Clears the instruction SRAM, streams in a program image with a valid/ready handshake, then pulses GPP reset and start.
- Waits for Done under a cycle watchdog and reports completion or an error code.
- Generalises fixed-depth, fixed-width bench-driven loading to parametrised width/depth with variable image length and timeout.

---
 rtl/gpp_boot_ctrl_if.sv | 13 +
 rtl/gpp_boot_ctrl.sv | 154 +++++++++++++++
 tb/tb_gpp_boot_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpp_boot_ctrl_if.sv
// Host image stream into the GPP boot sequencer: word handshake plus expected checksum.
`timescale 1ns/1ps
interface gpp_boot_ctrl_if #(
    parameter int D_WIDTH = 32
);
    logic               Img_Valid;
    logic [D_WIDTH-1:0] Img_Data;
    logic               Img_Ready;
    logic [D_WIDTH-1:0] Img_Cksum;

    modport master (output Img_Valid, Img_Data, Img_Cksum, input  Img_Ready);
    modport slave  (input  Img_Valid, Img_Data, Img_Cksum, output Img_Ready);
endinterface

// File: rtl/gpp_boot_ctrl.sv
// GPP boot sequencer: clear SRAM, stream image, pulse GPP reset/start, watch Done under a watchdog.
// Optional image checksum check is compiled in with `define GPP_BOOT_CKSUM_EN.
`timescale 1ns/1ps
module gpp_boot_ctrl #(
    parameter int D_WIDTH  = 32,
    parameter int A_WIDTH  = 5,
    parameter int DEPTH    = 32,
    parameter int TO_WIDTH = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Boot_Start,
    input  logic [A_WIDTH:0]    Img_Len,
    input  logic [TO_WIDTH-1:0] Timeout_Lim,
    gpp_boot_ctrl_if.slave      img,
    output logic                Mem_Rst,
    output logic                Mem_En,
    output logic                Mem_RW,
    output logic [A_WIDTH-1:0]  Mem_Addr,
    output logic [D_WIDTH-1:0]  Mem_Data,
    output logic                Gpp_Rst,
    output logic                Gpp_Str,
    input  logic                Gpp_Done,
    output logic                Busy,
    output logic                Boot_Done,
    output logic [1:0]          Err,
    output logic [TO_WIDTH-1:0] Run_Cnt
);

    localparam logic [A_WIDTH:0] DEPTH_L = (A_WIDTH+1)'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_MCLR, S_LOAD, S_SETTLE, S_GRST, S_START, S_INIT, S_RUN, S_FINISH
    } state_t;

    state_t              state, nxt;
    logic [1:0]          err_nxt;
    logic [A_WIDTH:0]    len_q;
    logic [TO_WIDTH-1:0] to_q;
    logic [A_WIDTH-1:0]  idx;
    logic                hs;
    logic                last;
    logic [A_WIDTH:0]    len_eff;

`ifdef GPP_BOOT_CKSUM_EN
    logic [D_WIDTH-1:0]  cksum;
`endif

    assign hs      = (state == S_LOAD) && img.Img_Valid && img.Img_Ready;
    assign last    = ({1'b0, idx} == (len_q - (A_WIDTH+1)'(1)));
    assign len_eff = ((Img_Len == '0) || (Img_Len > DEPTH_L)) ? DEPTH_L : Img_Len;

    always_comb begin
        nxt     = state;
        err_nxt = Err;
        case (state)
            S_IDLE: begin
                if (Boot_Start) begin
                    nxt     = S_MCLR;
                    err_nxt = 2'd0;
                end
            end
            S_MCLR:   nxt = S_LOAD;
            S_LOAD: begin
                if (hs && last) nxt = S_SETTLE;
            end
            S_SETTLE: begin
`ifdef GPP_BOOT_CKSUM_EN
                if (cksum != img.Img_Cksum) begin
                    nxt     = S_IDLE;
                    err_nxt = 2'd2;
                end else begin
                    nxt = S_GRST;
                end
`else
                nxt = S_GRST;
`endif
            end
            S_GRST:   nxt = S_START;
            S_START:  nxt = S_INIT;
            S_INIT:   nxt = S_RUN;
            S_RUN: begin
                // Done takes priority over a watchdog expiry on the same edge
                if (Gpp_Done) begin
                    nxt = S_FINISH;
                end else if ((to_q != '0) && (Run_Cnt == (to_q - TO_WIDTH'(1)))) begin
                    nxt     = S_IDLE;
                    err_nxt = 2'd1;
                end
            end
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= S_IDLE;
            len_q         <= '0;
            to_q          <= '0;
            idx           <= '0;
            Err           <= '0;
            Run_Cnt       <= '0;
            Busy          <= 1'b0;
            Mem_Rst       <= 1'b0;
            img.Img_Ready <= 1'b0;
            Gpp_Rst       <= 1'b0;
            Gpp_Str       <= 1'b0;
            Boot_Done     <= 1'b0;
            Mem_En        <= 1'b0;
            Mem_RW        <= 1'b0;
            Mem_Addr      <= '0;
            Mem_Data      <= '0;
        end else begin
            state         <= nxt;
            Err           <= err_nxt;
            Busy          <= (nxt != S_IDLE);
            Mem_Rst       <= (nxt == S_MCLR);
            img.Img_Ready <= (nxt == S_LOAD);
            Gpp_Rst       <= (nxt == S_GRST);
            Gpp_Str       <= (nxt == S_START);
            Boot_Done     <= (nxt == S_FINISH);
            Mem_En        <= hs;
            Mem_RW        <= hs;
            if (hs) begin
                Mem_Addr <= idx;
                Mem_Data <= img.Img_Data;
                if (!last) idx <= idx + A_WIDTH'(1);
            end
            if ((state == S_IDLE) && Boot_Start) begin
                len_q   <= len_eff;
                to_q    <= Timeout_Lim;
                idx     <= '0;
                Run_Cnt <= '0;
            end else if ((state == S_RUN) && (Run_Cnt != '1)) begin
                Run_Cnt <= Run_Cnt + TO_WIDTH'(1);
            end
        end
    end

`ifdef GPP_BOOT_CKSUM_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cksum <= '0;
        end else if (state == S_MCLR) begin
            cksum <= '0;
        end else if (hs) begin
            cksum <= cksum ^ img.Img_Data;
        end
    end
`endif

endmodule

// File: tb/tb_gpp_boot_ctrl.sv
// Scoreboard bench for gpp_boot_ctrl: expected SRAM writes and per-boot outcomes are queued, a monitor checks them.
`timescale 1ns/1ps
module tb_gpp_boot_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEP = 32;
    localparam int TW = 16;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Boot_Start = 1'b0;
    logic [AW:0]   Img_Len = '0;
    logic [TW-1:0] Timeout_Lim = '0;
    logic          Mem_Rst, Mem_En, Mem_RW;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Data;
    logic          Gpp_Rst, Gpp_Str;
    logic          Gpp_Done = 1'b0;
    logic          Busy, Boot_Done;
    logic [1:0]    Err;
    logic [TW-1:0] Run_Cnt;

    always #5 Clk = ~Clk;

    gpp_boot_ctrl_if #(.D_WIDTH(DW)) img_if ();

    gpp_boot_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .DEPTH(DEP), .TO_WIDTH(TW)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Boot_Start (Boot_Start),
        .Img_Len    (Img_Len),
        .Timeout_Lim(Timeout_Lim),
        .img        (img_if),
        .Mem_Rst    (Mem_Rst),
        .Mem_En     (Mem_En),
        .Mem_RW     (Mem_RW),
        .Mem_Addr   (Mem_Addr),
        .Mem_Data   (Mem_Data),
        .Gpp_Rst    (Gpp_Rst),
        .Gpp_Str    (Gpp_Str),
        .Gpp_Done   (Gpp_Done),
        .Busy       (Busy),
        .Boot_Done  (Boot_Done),
        .Err        (Err),
        .Run_Cnt    (Run_Cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [1:0] err; int done; int grst; int gstr; int mrst; logic [TW-1:0] run; } res_t;

    wr_t           wr_q[$];
    res_t          res_q[$];
    logic [DW-1:0] img_mem [0:DEP-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_res(input logic [1:0] err, input int done, input int grst, input int gstr,
                           input int mrst, input logic [TW-1:0] run);
        res_t r;
        r.err = err; r.done = done; r.grst = grst; r.gstr = gstr; r.mrst = mrst; r.run = run;
        res_q.push_back(r);
    endtask

    // Monitor: pops one expected write per Mem_En cycle and one outcome per Busy falling edge.
    initial begin : monitor
        wr_t  w;
        res_t r;
        int   c_done = 0, c_grst = 0, c_gstr = 0, c_mrst = 0;
        logic prev_busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (Mem_En) begin
                check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("wr_addr", 64'(Mem_Addr), 64'(w.addr));
                    check("wr_data", 64'(Mem_Data), 64'(w.data));
                    check("wr_rw",   64'(Mem_RW), 64'd1);
                end
            end
            c_done += int'(Boot_Done);
            c_grst += int'(Gpp_Rst);
            c_gstr += int'(Gpp_Str);
            c_mrst += int'(Mem_Rst);
            if (prev_busy && !Busy) begin
                check("res_expected", 64'(res_q.size() != 0), 64'd1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    check("res_err",       64'(Err), 64'(r.err));
                    check("res_run_cnt",   64'(Run_Cnt), 64'(r.run));
                    check("res_boot_done", 64'(c_done), 64'(r.done));
                    check("res_gpp_rst",   64'(c_grst), 64'(r.grst));
                    check("res_gpp_str",   64'(c_gstr), 64'(r.gstr));
                    check("res_mem_rst",   64'(c_mrst), 64'(r.mrst));
                end
                c_done = 0; c_grst = 0; c_gstr = 0; c_mrst = 0;
            end
            prev_busy = Busy;
        end
    end

    task automatic start_boot(input logic [AW:0] len, input logic [TW-1:0] lim);
        @(negedge Clk);
        Img_Len = len; Timeout_Lim = lim; Boot_Start = 1'b1;
        @(negedge Clk);
        Boot_Start = 1'b0;
    endtask

    // Offers img_mem[0..n-1]; a word counts as taken when Valid and Ready were both high at the edge.
    task automatic load(input int n, input bit toggle);
        int i = 0, cyc = 0;
        bit ph = 1'b1, pv = 1'b0, pr = 1'b0;
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.addr = AW'(k); w.data = img_mem[k];
            wr_q.push_back(w);
        end
        while (cyc < 400) begin
            if (pv && pr) i++;
            if (i >= n) break;
            img_if.Img_Valid = toggle ? ph : 1'b1;
            img_if.Img_Data  = img_mem[i];
            ph = ~ph;
            pv = img_if.Img_Valid;
            pr = img_if.Img_Ready;
            @(negedge Clk);
            cyc++;
        end
        img_if.Img_Valid = 1'b0;
        check("load_words", 64'(i), 64'(n));
    endtask

    task automatic wait_str();
        int c = 0;
        while (!Gpp_Str && c < 300) begin @(negedge Clk); c++; end
        check("gpp_str_seen", 64'(Gpp_Str), 64'd1);
    endtask

    task automatic pulse_done(input int m);
        repeat (m) @(negedge Clk);
        Gpp_Done = 1'b1;
        @(negedge Clk);
        Gpp_Done = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (Busy && c < 400) begin @(negedge Clk); c++; end
        check("idle_reached", 64'(Busy), 64'd0);
        @(negedge Clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        img_if.Img_Valid = 1'b0;
        img_if.Img_Data  = '0;
        img_if.Img_Cksum = '0;

        #12;
        check("reset_ctrl", 64'({Busy, img_if.Img_Ready, Mem_Rst, Mem_En, Mem_RW, Gpp_Rst, Gpp_Str,
                                 Boot_Done, Err, Mem_Addr}), 64'd0);
        check("reset_data", 64'({Mem_Data, Run_Cnt}), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Four words, Valid held high (already high before LOAD), Done 10 cycles after Str.
        img_mem[0] = 32'h11; img_mem[1] = 32'h22; img_mem[2] = 32'h33; img_mem[3] = 32'h44;
        exp_res(2'd0, 1, 1, 1, 1, 16'd9);
        start_boot(6'd4, 16'd0);
        load(4, 1'b0);
        wait_str();
        pulse_done(10);
        wait_idle();

        // Len 0 selects full depth; Valid toggles every other cycle.
        for (int k = 0; k < DEP; k++) img_mem[k] = 32'h1000_0000 + 32'(k * 3);
        exp_res(2'd0, 1, 1, 1, 1, 16'd2);
        start_boot(6'd0, 16'd0);
        load(DEP, 1'b1);
        wait_str();
        pulse_done(3);
        wait_idle();

        // Watchdog: limit 5, no Done.
        img_mem[0] = 32'hDEAD_0001;
        exp_res(2'd1, 0, 1, 1, 1, 16'd5);
        start_boot(6'd1, 16'd5);
        load(1, 1'b0);
        wait_idle();
        repeat (3) @(negedge Clk);
        check("err_sticky", 64'(Err), 64'd1);

        // Reset mid-LOAD after two words, then a clean reload.
        img_mem[0] = 32'hA0A0_0000; img_mem[1] = 32'hA0A0_0001;
        exp_res(2'd0, 0, 0, 0, 1, 16'd0);
        start_boot(6'd8, 16'd0);
        load(2, 1'b0);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({Busy, img_if.Img_Ready, Mem_Rst, Mem_En, Mem_RW, Gpp_Rst, Gpp_Str,
                                 Boot_Done, Err, Mem_Addr}), 64'd0);
        check("abort_data", 64'({Mem_Data, Run_Cnt}), 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        img_mem[0] = 32'h5555_0000; img_mem[1] = 32'h5555_0001; img_mem[2] = 32'h5555_0002;
        exp_res(2'd0, 1, 1, 1, 1, 16'd3);
        start_boot(6'd3, 16'd0);
        load(3, 1'b0);
        wait_str();
        pulse_done(4);
        wait_idle();

        // Done held through LOAD and Boot_Start re-pulsed in RUN are both ignored.
        img_mem[0] = 32'h0000_BEEF; img_mem[1] = 32'h0000_CAFE;
        exp_res(2'd0, 1, 1, 1, 1, 16'd7);
        Gpp_Done = 1'b1;
        start_boot(6'd2, 16'd0);
        load(2, 1'b0);
        wait_str();
        Gpp_Done = 1'b0;
        repeat (3) @(negedge Clk);
        Boot_Start = 1'b1;
        @(negedge Clk);
        Boot_Start = 1'b0;
        repeat (4) @(negedge Clk);
        Gpp_Done = 1'b1;
        @(negedge Clk);
        Gpp_Done = 1'b0;
        wait_idle();
        repeat (3) @(negedge Clk);
        check("no_restart", 64'(Busy), 64'd0);

`ifdef GPP_BOOT_CKSUM_EN
        // Checksum 0xA5 ^ 0x0F = 0xAA: match runs, mismatch stops before GPP reset/start.
        img_mem[0] = 32'hA5; img_mem[1] = 32'h0F;
        img_if.Img_Cksum = 32'hAA;
        exp_res(2'd0, 1, 1, 1, 1, 16'd3);
        start_boot(6'd2, 16'd0);
        load(2, 1'b0);
        wait_str();
        pulse_done(4);
        wait_idle();

        img_if.Img_Cksum = 32'h00;
        exp_res(2'd2, 0, 0, 0, 1, 16'd0);
        start_boot(6'd2, 16'd0);
        load(2, 1'b0);
        wait_idle();
`endif

        repeat (2) @(negedge Clk);
        check("wr_queue_drained",  64'(wr_q.size()), 64'd0);
        check("res_queue_drained", 64'(res_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
